uart_tx_queue: RTL and testbench

Byte queue between the ROM-dump CPU's SEND path and the `buart` transmitter. It accepts bytes from the CPU in single-cycle pushes, stores them in a small FIFO, and drains them into `buart` one at a time: one-cycle `wr` strobe, gated by `busy`. The CPU no longer spin-waits on `busy`; it stalls only when the queue is full.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_tx_queue_if.sv | 33 +++
 rtl/byte_fifo.sv | 66 ++++++
 rtl/uart_tx_queue.sv | 73 +++++++
 tb/tb_uart_tx_queue.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit queue.
// Drain FSM states and the byte width seen by buart.
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GUARD = 1'b1
    } drain_state_e;

endpackage

// File: rtl/uart_tx_queue_if.sv
// CPU push side and buart strobe side of the transmit queue.
// master drives the queue inputs, slave is the queue itself.
interface uart_tx_queue_if #(
    parameter int DEPTH = 16
);
    import uart_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic                   flush;
    logic                   push;
    logic [UART_BYTE_W-1:0] push_data;
    logic                   push_ready;
    logic                   overflow;
    logic [AW:0]            level;
    logic                   empty;
    logic                   uart_busy;
    logic                   uart_wr;
    logic [UART_BYTE_W-1:0] uart_data;

    modport master (
        output flush, push, push_data, uart_busy,
        input  push_ready, overflow, level, empty,
        input  uart_wr, uart_data
    );

    modport slave (
        input  flush, push, push_data, uart_busy,
        output push_ready, overflow, level, empty,
        output uart_wr, uart_data
    );

endinterface

// File: rtl/byte_fifo.sv
// Circular byte buffer with registered read and registered flags.
// The read register only loads on a pop, so it holds the last popped byte.
module byte_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   resetq,
    input  logic                   clr,
    input  logic                   wr_en,
    input  logic [UART_BYTE_W-1:0] wr_data,
    input  logic                   rd_en,
    output logic [UART_BYTE_W-1:0] rd_data,
    output logic [AW:0]            count,
    output logic                   full,
    output logic                   empty
);

    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [UART_BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]          wptr;
    logic [AW-1:0]          rptr;
    logic [AW:0]            cnt_nx;
    logic                   do_wr;
    logic                   do_rd;

    assign do_wr  = wr_en && !full && !clr;
    assign do_rd  = rd_en && !empty && !clr;
    assign cnt_nx = count + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq)    rd_data <= '0;
        else if (do_rd) rd_data <= mem[rptr];
    end

    // Flags are registered from the next count so they track level exactly.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            wptr  <= wptr + {{(AW-1){1'b0}}, do_wr};
            rptr  <= rptr + {{(AW-1){1'b0}}, do_rd};
            count <= cnt_nx;
            full  <= (cnt_nx == FULL_CNT);
            empty <= (cnt_nx == '0);
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding buart: CPU pushes, drain FSM strobes wr when idle.
// The FIFO read register doubles as uart_data, loaded at each pop.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input logic             clk,
    input logic             resetq,
    uart_tx_queue_if.slave  bus
);

    drain_state_e           state;
    logic                   wr_q;
    logic                   ovf_q;
    logic                   pop;
    logic                   full;
    logic                   empty;
    logic [AW:0]            count;
    logic [UART_BYTE_W-1:0] rd_data;

    assign pop = (state == S_IDLE) && !empty && !bus.uart_busy && !bus.flush;

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetq  (resetq),
        .clr     (bus.flush),
        .wr_en   (bus.push),
        .wr_data (bus.push_data),
        .rd_en   (pop),
        .rd_data (rd_data),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    // S_GUARD skips one cycle: buart raises busy only after seeing wr.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state <= S_IDLE;
            wr_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else if (bus.flush) begin
            state <= S_IDLE;
            wr_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            if (bus.push && full) ovf_q <= 1'b1;
            unique case (state)
                S_IDLE: begin
                    wr_q <= pop;
                    if (pop) state <= S_GUARD;
                end
                S_GUARD: begin
                    wr_q  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.push_ready = !full;
    assign bus.overflow   = ovf_q;
    assign bus.level      = count;
    assign bus.empty      = empty;
    assign bus.uart_wr    = wr_q;
    assign bus.uart_data  = rd_data;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Randomized bench for uart_tx_queue against a queue-based reference model.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_uart_tx_queue;
    import uart_pkg::*;

    localparam int DEPTH = 16;

    logic clk    = 1'b0;
    logic resetq = 1'b1;

    always #5 clk = ~clk;

    uart_tx_queue_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_queue #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .resetq (resetq),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] q [$];
    bit         m_ovf;
    bit         m_wr;
    logic [7:0] m_data;

    int busy_mode;
    bit busy_hold;
    int busy_cnt;
    int cyc;

    logic [7:0] sd [$];
    int         sc [$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf    = 1'b0;
        m_wr     = 1'b0;
        m_data   = 8'h00;
        busy_cnt = 0;
    endtask

    // A strobe needs a byte already queued, an idle buart and no strobe
    // in the current cycle; pushes are admitted only below DEPTH.
    task automatic model_edge();
        bit was_full;
        bit do_pop;
        was_full = (q.size() == DEPTH);
        do_pop   = !m_wr && (q.size() != 0) && !bus.uart_busy;
        if (bus.flush) begin
            q.delete();
            m_ovf = 1'b0;
            m_wr  = 1'b0;
        end else begin
            if (bus.push && was_full) m_ovf = 1'b1;
            if (do_pop) begin
                m_data = q.pop_front();
                m_wr   = 1'b1;
            end else begin
                m_wr = 1'b0;
            end
            if (bus.push && !was_full) q.push_back(bus.push_data);
        end
    endtask

    task automatic check_outputs(string pfx);
        chk({pfx, ".push_ready"}, bus.push_ready, q.size() < DEPTH);
        chk({pfx, ".empty"},      bus.empty,      q.size() == 0);
        chk({pfx, ".level"},      bus.level,      q.size());
        chk({pfx, ".overflow"},   bus.overflow,   m_ovf);
        chk({pfx, ".uart_wr"},    bus.uart_wr,    m_wr);
        chk({pfx, ".uart_data"},  bus.uart_data,  m_data);
    endtask

    task automatic update_busy();
        bit b;
        case (busy_mode)
            1: begin
                b = (busy_cnt > 0);
                if (b) busy_cnt--;
                if (m_wr) busy_cnt = 20;
                bus.uart_busy = b;
            end
            2:       bus.uart_busy = ($urandom_range(0, 2) == 0);
            default: bus.uart_busy = busy_hold;
        endcase
    endtask

    task automatic step(bit p, logic [7:0] d, bit f);
        bus.push      = p;
        bus.push_data = d;
        bus.flush     = f;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        check_outputs("cyc");
        if (bus.uart_wr) begin
            sd.push_back(bus.uart_data);
            sc.push_back(cyc);
        end
        update_busy();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        int lvl_before;
        int nxt;
        int n;
        bit p;

        bus.push      = 1'b0;
        bus.push_data = 8'h00;
        bus.flush     = 1'b0;
        bus.uart_busy = 1'b0;
        busy_mode     = 0;
        busy_hold     = 1'b0;
        model_reset();

        #2 resetq = 1'b0;
        #1 check_outputs("rst0");
        @(negedge clk);
        @(negedge clk);
        resetq = 1'b1;
        cyc    = 0;

        // Idle-UART latency: push at cycle 10, strobe at cycle 12.
        while (cyc < 10) idle(1);
        sd.delete();
        sc.delete();
        step(1'b1, 8'h95, 1'b0);
        chk("lat.level1", bus.level, 1);
        idle(6);
        chk("lat.count", sd.size(), 1);
        if (sd.size() >= 1) begin
            chk("lat.data", sd[0], 8'h95);
            chk("lat.cycle", sc[0], 12);
        end
        chk("lat.level0", bus.level, 0);

        // Busy gating with a 20-cycle busy after each strobe.
        sd.delete();
        sc.delete();
        busy_mode = 1;
        busy_cnt  = 0;
        step(1'b1, 8'h28, 1'b0);
        step(1'b1, 8'h36, 1'b0);
        step(1'b1, 8'hB0, 1'b0);
        idle(80);
        chk("gate.count", sd.size(), 3);
        if (sd.size() == 3) begin
            chk("gate.d0", sd[0], 8'h28);
            chk("gate.d1", sd[1], 8'h36);
            chk("gate.d2", sd[2], 8'hB0);
            chk("gate.gap01", sc[1] - sc[0], 22);
            chk("gate.gap12", sc[2] - sc[1], 22);
        end

        // Fill with buart busy, overflow on the 17th, then drain 16.
        busy_mode     = 0;
        busy_hold     = 1'b1;
        bus.uart_busy = 1'b1;
        sd.delete();
        sc.delete();
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 8'hA0 + 8'(i), 1'b0);
            if (i == 15) chk("full.ready16", bus.push_ready, 0);
        end
        chk("full.ovf", bus.overflow, 1);
        chk("full.level", bus.level, 16);
        busy_hold     = 1'b0;
        bus.uart_busy = 1'b0;
        idle(40);
        chk("full.count", sd.size(), 16);
        for (int i = 0; i < 16 && i < sd.size(); i++)
            chk($sformatf("full.d%0d", i), sd[i], 8'hA0 + 8'(i));

        // Wrap-around stream with random busy.
        busy_mode = 2;
        sd.delete();
        sc.delete();
        nxt = 0;
        n   = 0;
        while (sd.size() < 40 && n < 3000) begin
            p = (nxt < 40) && (q.size() < DEPTH) && ($urandom_range(0, 3) != 0);
            lvl_before = q.size();
            step(p, 8'(nxt), 1'b0);
            if (p) nxt++;
            if (p && m_wr) chk("wrap.level_const", bus.level, lvl_before);
            n++;
        end
        chk("wrap.count", sd.size(), 40);
        for (int i = 0; i < 40 && i < sd.size(); i++)
            chk($sformatf("wrap.d%0d", i), sd[i], 8'(i));

        // Flush during the strobe cycle; overflow is still set from above.
        busy_mode     = 0;
        busy_hold     = 1'b1;
        bus.uart_busy = 1'b1;
        idle(2);
        for (int i = 0; i < 5; i++) step(1'b1, 8'h50 + 8'(i), 1'b0);
        sd.delete();
        sc.delete();
        busy_hold     = 1'b0;
        bus.uart_busy = 1'b0;
        n = 0;
        while (!bus.uart_wr && n < 10) begin
            idle(1);
            n++;
        end
        chk("flush.strobe_seen", bus.uart_wr, 1);
        chk("flush.ovf_before", bus.overflow, 1);
        step(1'b0, 8'h00, 1'b1);
        chk("flush.level", bus.level, 0);
        chk("flush.ovf", bus.overflow, 0);
        idle(20);
        chk("flush.strobes", sd.size(), 1);
        if (sd.size() >= 1) chk("flush.d0", sd[0], 8'h50);

        // Asynchronous reset in the middle of a stream.
        busy_mode = 2;
        for (int i = 0; i < 6; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0);
        idle(3);
        bus.push = 1'b0;
        #2 resetq = 1'b0;
        model_reset();
        #1 check_outputs("rst1");
        @(negedge clk);
        @(negedge clk);
        check_outputs("rst1hold");
        resetq        = 1'b1;
        busy_mode     = 0;
        busy_hold     = 1'b0;
        bus.uart_busy = 1'b0;
        sd.delete();
        sc.delete();
        idle(10);
        chk("rst.no_strobe", sd.size(), 0);
        step(1'b1, 8'h3C, 1'b0);
        idle(4);
        chk("rst.new_count", sd.size(), 1);
        if (sd.size() >= 1) chk("rst.new_data", sd[0], 8'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
